// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV64M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN  = 64;
  localparam int ITERS = XLEN;

  localparam logic [63:0] DIV0_QUOT = '1;
  localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } muldiv_state_t;

  function automatic logic op_is_div(muldiv_op_t o);
    return o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/muldiv_sign_adjust.sv
// Turns unsigned magnitude results into the architectural RV64M result,
// including sign restoration and the divide-by-zero / overflow values.
module muldiv_sign_adjust
  import muldiv_pkg::*;
(
  input  muldiv_op_t        op,
  input  logic [2*XLEN-1:0] work,
  input  logic              s1,
  input  logic              s2,
  input  logic              div_zero,
  input  logic              div_ovf,
  input  logic              mul_zero,
  input  logic [XLEN-1:0]   a_raw,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;

  // Multiply keeps the full product in work; divide keeps {remainder, quotient}.
  always_comb begin
    prod   = (s1 ^ s2) ? -work : work;
    quot   = (s1 ^ s2) ? -work[XLEN-1:0] : work[XLEN-1:0];
    rem    = s1 ? -work[2*XLEN-1:XLEN] : work[2*XLEN-1:XLEN];
    result = '0;
    unique case (op)
      OP_MUL:                       result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = div_zero ? DIV0_QUOT :
                                             div_ovf  ? INT64_MIN : quot;
      default:                      result = div_zero ? a_raw :
                                             div_ovf  ? '0 : rem;
    endcase
    // A zero multiply operand may have skipped the iterations entirely.
    if (mul_zero) result = '0;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 64-bit RV64M multiply/divide unit (shift-add / restoring divide).
// Optional macro MULDIV_FAST_PATH_EN lets trivial cases bypass the iterations.
module muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int ITERS = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            reg_write
);
  import muldiv_pkg::*;

  localparam int CW = $clog2(ITERS) + 1;

  muldiv_state_t     state, state_nx;
  muldiv_op_t        op_q, op_in;
  logic [4:0]        rd_q, rd_hold;
  logic [XLEN-1:0]   a_raw, operand, result_hold, adj_result;
  logic [2*XLEN-1:0] work, work_nx;
  logic [CW-1:0]     cnt;
  logic              s1, s2, div_zero, div_ovf, mul_zero;
  logic              in_div, in_s1, in_s2, in_div_zero, in_div_ovf, in_mul_zero, fast;
  logic [XLEN-1:0]   a_mag_in, b_mag_in;
  logic [XLEN:0]     trial, mac;

  always_comb begin
    op_in       = muldiv_op_t'(op);
    in_div      = op_is_div(op_in);
    in_s1       = (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && rs1_data[XLEN-1];
    in_s2       = (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && rs2_data[XLEN-1];
    a_mag_in    = in_s1 ? -rs1_data : rs1_data;
    b_mag_in    = in_s2 ? -rs2_data : rs2_data;
    in_div_zero = in_div && (rs2_data == '0);
    in_div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (rs1_data == INT64_MIN) && (rs2_data == '1);
    in_mul_zero = !in_div && ((rs1_data == '0) || (rs2_data == '0));
  end

`ifdef MULDIV_FAST_PATH_EN
  assign fast = in_div_zero | in_div_ovf | in_mul_zero;
`else
  assign fast = 1'b0;
`endif

  // operand holds the multiplicand or the divisor; work holds product or {rem, quot}.
  always_comb begin
    trial = {work[2*XLEN-1:XLEN], work[XLEN-1]} - {1'b0, operand};
    mac   = {1'b0, work[2*XLEN-1:XLEN]} + {1'b0, operand};
    if (op_is_div(op_q)) begin
      if (!trial[XLEN]) work_nx = {trial[XLEN-1:0], work[XLEN-2:0], 1'b1};
      else              work_nx = {work[2*XLEN-2:0], 1'b0};
    end else if (work[0]) begin
      work_nx = {mac, work[XLEN-1:1]};
    end else begin
      work_nx = {1'b0, work[2*XLEN-1:1]};
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (start) state_nx = fast ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt == CW'(ITERS - 1)) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_q        <= OP_MUL;
      rd_q        <= '0;
      rd_hold     <= '0;
      a_raw       <= '0;
      operand     <= '0;
      work        <= '0;
      cnt         <= '0;
      s1          <= 1'b0;
      s2          <= 1'b0;
      div_zero    <= 1'b0;
      div_ovf     <= 1'b0;
      mul_zero    <= 1'b0;
      result_hold <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && start) begin
        op_q     <= op_in;
        rd_q     <= rd_in;
        a_raw    <= rs1_data;
        s1       <= in_s1;
        s2       <= in_s2;
        div_zero <= in_div_zero;
        div_ovf  <= in_div_ovf;
        mul_zero <= in_mul_zero;
        operand  <= in_div ? b_mag_in : a_mag_in;
        work     <= {{XLEN{1'b0}}, (in_div ? a_mag_in : b_mag_in)};
        cnt      <= '0;
      end else if (state == ST_CALC) begin
        work <= work_nx;
        cnt  <= cnt + CW'(1);
      end
      if (state == ST_DONE) begin
        result_hold <= adj_result;
        rd_hold     <= rd_q;
      end
    end
  end

  muldiv_sign_adjust u_sign_adjust (
    .op       (op_q),
    .work     (work),
    .s1       (s1),
    .s2       (s2),
    .div_zero (div_zero),
    .div_ovf  (div_ovf),
    .mul_zero (mul_zero),
    .a_raw    (a_raw),
    .result   (adj_result)
  );

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign result    = done ? adj_result : result_hold;
  assign rd_out    = done ? rd_q : rd_hold;
  assign reg_write = done && (rd_out != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results are queued at issue and
// checked (value, rd, write strobe, latency) when done pulses.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [63:0] rs1_data = '0;
  logic [63:0] rs2_data = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, reg_write;
  logic [63:0] result;
  logic [4:0]  rd_out;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int done_seen = 0;
  int pushed = 0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          lat;
    int          start_cyc;
    string       tag;
  } exp_t;

  exp_t sb[$];

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_in     (rd_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .reg_write (reg_write)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent arithmetic reference used for the randomised operations.
  function automatic logic [63:0] refModel(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       p;
    logic signed [63:0] sa, sbv;
    sa  = a;
    sbv = b;
    case (o)
      3'd0: return a * b;
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
      3'd4: if (b == 0) return ONES; else if (a == MIN64 && b == ONES) return MIN64; else return sa / sbv;
      3'd5: if (b == 0) return ONES; else return a / b;
      3'd6: if (b == 0) return a; else if (a == MIN64 && b == ONES) return 64'd0; else return sa % sbv;
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int expLat(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    logic trivial;
    trivial = (o >= 3'd4 && b == 0) ||
              ((o == 3'd4 || o == 3'd6) && a == MIN64 && b == ONES) ||
              (o < 3'd4 && (a == 0 || b == 0));
`ifdef MULDIV_FAST_PATH_EN
    return trivial ? 1 : 65;
`else
    return trivial ? 65 : 65;
`endif
  endfunction

  task automatic applyStimulus(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                               input logic [4:0] rd, input string tag, input logic [63:0] exp_res);
    exp_t e;
    @(negedge clk);
    op       = o;
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
    start    = 1'b1;
    e.res       = exp_res;
    e.rd        = rd;
    e.lat       = expLat(o, a, b);
    e.start_cyc = cyc;
    e.tag       = tag;
    sb.push_back(e);
    pushed++;
    @(negedge clk);
    start    = 1'b0;
    op       = 3'd0;
    rs1_data = $urandom;
    rs2_data = $urandom;
    rd_in    = 5'd0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("drain", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      done_seen++;
      if (sb.size() == 0) begin
        checkOutput("spurious_done", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput({e.tag, "_result"}, result, e.res);
        checkOutput({e.tag, "_rd"}, 64'(rd_out), 64'(e.rd));
        checkOutput({e.tag, "_wr"}, 64'(reg_write), 64'(e.rd != 5'd0));
        checkOutput({e.tag, "_lat"}, 64'(cyc - e.start_cyc), 64'(e.lat));
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0]  ro;
    logic [63:0] ra, rb;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_result", result, 64'd0);
    checkOutput("rst_rd", 64'(rd_out), 64'd0);
    checkOutput("rst_wr", 64'(reg_write), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(3'd0, 64'd7, -64'sd3, 5'd5, "mul", 64'hFFFF_FFFF_FFFF_FFEB);
    checkOutput("mul_busy", 64'(busy), 64'd1);
    waitDrain();
    applyStimulus(3'd3, ONES, 64'd2, 5'd6, "mulhu", 64'd1);
    waitDrain();
    applyStimulus(3'd1, ONES, ONES, 5'd7, "mulh", 64'd0);
    waitDrain();
    applyStimulus(3'd4, -64'sd7, 64'd2, 5'd8, "div", 64'hFFFF_FFFF_FFFF_FFFD);
    waitDrain();
    applyStimulus(3'd6, -64'sd7, 64'd2, 5'd9, "rem", ONES);
    waitDrain();
    applyStimulus(3'd5, 64'd10, 64'd0, 5'd10, "divu0", ONES);
    waitDrain();
    applyStimulus(3'd6, MIN64, ONES, 5'd11, "removf", 64'd0);
    waitDrain();
    applyStimulus(3'd4, MIN64, ONES, 5'd12, "divovf", MIN64);
    waitDrain();
    applyStimulus(3'd7, 64'd13, 64'd0, 5'd13, "remu0", 64'd13);
    waitDrain();

    applyStimulus(3'd5, 64'd100, 64'd7, 5'd3, "divu_ign", 64'd14);
    repeat (9) @(negedge clk);
    op = 3'd0; rs1_data = 64'd5; rs2_data = 64'd5; rd_in = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDrain();
    repeat (80) @(negedge clk);

    applyStimulus(3'd0, 64'd5, 64'd6, 5'd0, "rd0", 64'd30);
    waitDrain();

    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      rb = (i % 3 == 0) ? 64'd0 : ((i % 3 == 1) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom});
      applyStimulus(ro, ra, rb, 5'($urandom_range(1, 31)), $sformatf("rnd%0d", i), refModel(ro, ra, rb));
      waitDrain();
    end

    applyStimulus(3'd5, 64'hFFFF_0000_1234_5678, 64'd3, 5'd9, "abort", 64'd0);
    repeat (30) @(negedge clk);
    checkOutput("abort_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    pushed -= sb.size();
    sb.delete();
    #1;
    checkOutput("abort_busy0", 64'(busy), 64'd0);
    checkOutput("abort_done0", 64'(done), 64'd0);
    checkOutput("abort_result0", result, 64'd0);
    checkOutput("abort_rd0", 64'(rd_out), 64'd0);
    checkOutput("abort_wr0", 64'(reg_write), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);

    applyStimulus(3'd0, 64'd3, 64'd4, 5'd7, "mul_after", 64'd12);
    waitDrain();
    repeat (5) @(negedge clk);
    checkOutput("done_count", 64'(done_seen), 64'(pushed));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
